// File: rtl/cpu_retire_pkg.sv
// cpu_retire_pkg: shared CPU defines for the retire stage.
//   TAG_SIZE  - width of the writeback tag used across the pipeline
//   ST_INIT / ST_RUN - retire FSM state encodings
//   NUM_REGS  - number of architectural registers held in the array (x1..x31)
package cpu_retire_pkg;
  localparam int TAG_SIZE = 8;
  localparam int NUM_REGS = 31;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/cpu_retire_if.sv
// cpu_retire_if: writeback bundle, decode read ports and retire acknowledge.
//   master - pipeline side: drives i_* (tag, rd index/data, pc_next, read indices)
//   slave  - retire stage: drives o_* (read data, committed tag/pc, ready, instret)
interface cpu_retire_if import cpu_retire_pkg::*; #(
  parameter int TAG_W = TAG_SIZE
) ();
  logic [TAG_W-1:0] i_tag;
  logic [4:0]       i_inst_rd;
  logic [31:0]      i_rd;
  logic [31:0]      i_pc_next;
  logic [4:0]       i_rs1_idx;
  logic [4:0]       i_rs2_idx;
  logic [31:0]      o_rs1;
  logic [31:0]      o_rs2;
  logic [TAG_W-1:0] o_tag;
  logic [31:0]      o_pc_next;
  logic             o_ready;
  logic [63:0]      o_instret;

  modport master (
    output i_tag, i_inst_rd, i_rd, i_pc_next, i_rs1_idx, i_rs2_idx,
    input  o_rs1, o_rs2, o_tag, o_pc_next, o_ready, o_instret
  );

  modport slave (
    input  i_tag, i_inst_rd, i_rd, i_pc_next, i_rs1_idx, i_rs2_idx,
    output o_rs1, o_rs2, o_tag, o_pc_next, o_ready, o_instret
  );
endinterface

// File: rtl/cpu_retire_regs.sv
// cpu_retire_regs: 31x32 register array (x1..x31), one write port, two
// combinational read ports. Index 0 always reads 0 and is never written.
//   clk            - write clock
//   we/waddr/wdata - write port
//   raddr1/raddr2  - read indices; rdata1/rdata2 - read data
// The array has no reset; it is cleared by the retire stage's INIT sweep.
module cpu_retire_regs import cpu_retire_pkg::*; (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  // Entry k holds register x(k+1).
  logic [31:0] mem [0:NUM_REGS-1];

  // Write port; x0 is hardwired so writes to index 0 are dropped.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      mem[waddr - 5'd1] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem[raddr1 - 5'd1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem[raddr2 - 5'd1];
endmodule

// File: rtl/cpu_retire.sv
// cpu_retire: retire/commit stage with register file.
//   i_clock    - single clock, rising edge
//   i_reset_n  - asynchronous active-low reset
//   bus        - cpu_retire_if slave: writeback bundle in, read data and
//                commit acknowledge (o_tag, o_pc_next, o_instret, o_ready) out
// After reset an INIT sweep zeroes x1..x31 (one per cycle), then RUN commits
// an instruction on every edge where the incoming tag differs from o_tag.
// Optional: define CPU_RETIRE_BYPASS_EN to forward the committing rd data to
// a same-cycle read of the same register.
module cpu_retire import cpu_retire_pkg::*; #(
  parameter int TAG_W       = TAG_SIZE,
  parameter int INIT_CYCLES = NUM_REGS
) (
  input logic        i_clock,
  input logic        i_reset_n,
  cpu_retire_if.slave bus
);
  localparam logic [4:0] SWEEP_LAST = 5'(INIT_CYCLES);

  logic [0:0]       state_r;
  logic [4:0]       sweep_r;
  logic [TAG_W-1:0] tag_r;
  logic [31:0]      pc_r;
  logic [63:0]      instret_r;

  logic        commit_s;
  logic        we_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic [31:0] rf_rs1_s;
  logic [31:0] rf_rs2_s;
  logic [31:0] rs1_s;
  logic [31:0] rs2_s;

  // The tag itself is the handshake: a new value means a new instruction.
  assign commit_s = (state_r == ST_RUN) && (bus.i_tag != tag_r);

  // Write port select: the INIT sweep owns the port, RUN uses the commit.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = 5'd0;
    wdata_s = 32'd0;
    if (state_r == ST_INIT) begin
      we_s    = 1'b1;
      waddr_s = sweep_r;
      wdata_s = 32'd0;
    end else begin
      we_s    = commit_s && (bus.i_inst_rd != 5'd0);
      waddr_s = bus.i_inst_rd;
      wdata_s = bus.i_rd;
    end
  end

  cpu_retire_regs u_regs (
    .clk    (i_clock),
    .we     (we_s),
    .waddr  (waddr_s),
    .wdata  (wdata_s),
    .raddr1 (bus.i_rs1_idx),
    .raddr2 (bus.i_rs2_idx),
    .rdata1 (rf_rs1_s),
    .rdata2 (rf_rs2_s)
  );

  // Read data: zero while INIT is clearing, optional same-cycle forwarding.
  always_comb begin
    rs1_s = 32'd0;
    rs2_s = 32'd0;
    if (state_r == ST_RUN) begin
      rs1_s = rf_rs1_s;
      rs2_s = rf_rs2_s;
`ifdef CPU_RETIRE_BYPASS_EN
      if (commit_s && (bus.i_inst_rd != 5'd0) && (bus.i_inst_rd == bus.i_rs1_idx)) begin
        rs1_s = bus.i_rd;
      end else begin
        rs1_s = rf_rs1_s;
      end
      if (commit_s && (bus.i_inst_rd != 5'd0) && (bus.i_inst_rd == bus.i_rs2_idx)) begin
        rs2_s = bus.i_rd;
      end else begin
        rs2_s = rf_rs2_s;
      end
`endif
    end else begin
      rs1_s = 32'd0;
      rs2_s = 32'd0;
    end
  end

  // FSM, sweep counter and commit state.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= ST_INIT;
      sweep_r   <= 5'd1;
      tag_r     <= '0;
      pc_r      <= 32'd0;
      instret_r <= 64'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (sweep_r == SWEEP_LAST) begin
            state_r <= ST_RUN;
          end else begin
            sweep_r <= sweep_r + 5'd1;
          end
        end
        ST_RUN: begin
          if (commit_s) begin
            tag_r     <= bus.i_tag;
            pc_r      <= bus.i_pc_next;
            instret_r <= instret_r + 64'd1;
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.o_rs1     = rs1_s;
  assign bus.o_rs2     = rs2_s;
  assign bus.o_tag     = tag_r;
  assign bus.o_pc_next = pc_r;
  assign bus.o_instret = instret_r;
  assign bus.o_ready   = (state_r == ST_RUN);
endmodule

// File: tb/tb_cpu_retire.sv
// tb_cpu_retire: scoreboard bench for cpu_retire. Each driven commit pushes the
// expected (tag, pc_next, instret) into a queue; it is popped and compared one
// edge later. Register contents are tracked in a small model array.
module tb_cpu_retire;
  localparam int TAG_W = 8;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      pc;
    logic [63:0]      cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  exp_t        sb_q[$];
  logic [63:0] model_cnt;
  logic [31:0] model_regs [0:31];

  cpu_retire_if #(.TAG_W(TAG_W)) bus ();

  cpu_retire #(.TAG_W(TAG_W), .INIT_CYCLES(31)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [TAG_W-1:0] tag, input logic [4:0] rd,
                          input logic [31:0] data, input logic [31:0] pc);
    exp_t e;
    bus.i_tag     = tag;
    bus.i_inst_rd = rd;
    bus.i_rd      = data;
    bus.i_pc_next = pc;
    model_cnt     = model_cnt + 64'd1;
    e.tag = tag;
    e.pc  = pc;
    e.cnt = model_cnt;
    sb_q.push_back(e);
    if (rd != 5'd0) model_regs[rd] = data;
  endtask

  task automatic retire_check();
    exp_t e;
    tick();
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("commit_tag", 64'(bus.o_tag), 64'(e.tag));
      check_val("commit_pc", 64'(bus.o_pc_next), 64'(e.pc));
      check_val("commit_cnt", bus.o_instret, e.cnt);
    end
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (!bus.o_ready && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 10) begin
        check_val("init_rd_zero", 64'(bus.o_rs1), 64'd0);
        check_val("init_tag_hold", 64'(bus.o_tag), 64'd0);
      end
    end
    check_val(tag, 64'(cyc), 64'd31);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_tag"}, 64'(bus.o_tag), 64'd0);
    check_val({tag, "_pc"}, 64'(bus.o_pc_next), 64'd0);
    check_val({tag, "_cnt"}, bus.o_instret, 64'd0);
    check_val({tag, "_rdy"}, 64'(bus.o_ready), 64'd0);
  endtask

  initial begin
    logic [31:0] old_x9;
    vectors     = 0;
    miscompares = 0;
    model_cnt   = 64'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    rst_n         = 1'b0;
    bus.i_tag     = '0;
    bus.i_inst_rd = 5'd0;
    bus.i_rd      = 32'd0;
    bus.i_pc_next = 32'd0;
    bus.i_rs1_idx = 5'd3;
    bus.i_rs2_idx = 5'd0;
    #2;
    check_outputs_zero("reset");

    // Sweep with tag held at 0: ready after exactly 31 edges.
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init_len");
    check_val("run_tag", 64'(bus.o_tag), 64'd0);
    check_val("run_cnt", bus.o_instret, 64'd0);
    for (int r = 1; r < 32; r++) begin
      bus.i_rs1_idx = 5'(r);
      bus.i_rs2_idx = 5'(r);
      #1;
      check_val("clr_rs1", 64'(bus.o_rs1), 64'd0);
      check_val("clr_rs2", 64'(bus.o_rs2), 64'd0);
    end

    // Single commit, then a held tag must not recount.
    bus.i_rs1_idx = 5'd5;
    drive_wb(8'd1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0104);
    retire_check();
    check_val("rs1_x5", 64'(bus.o_rs1), 64'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) tick();
    check_val("hold_cnt", bus.o_instret, 64'd1);
    check_val("hold_tag", 64'(bus.o_tag), 64'd1);

    // Back-to-back distinct tags, including an rd = 0 commit.
    drive_wb(8'd2, 5'd0, 32'd1, 32'h0000_0108);
    retire_check();
    drive_wb(8'd3, 5'd7, 32'd2, 32'h0000_010C);
    retire_check();
    drive_wb(8'd4, 5'd7, 32'd3, 32'h0000_0110);
    retire_check();
    bus.i_rs1_idx = 5'd0;
    bus.i_rs2_idx = 5'd7;
    #1;
    check_val("x0_zero", 64'(bus.o_rs1), 64'd0);
    check_val("x7_val", 64'(bus.o_rs2), 64'(model_regs[7]));
    check_val("b2b_cnt", bus.o_instret, 64'd4);

    // Same-cycle read of the register being committed.
    old_x9 = model_regs[9];
    bus.i_rs2_idx = 5'd9;
    drive_wb(8'd5, 5'd9, 32'h0000_0055, 32'h0000_0114);
    #1;
`ifdef CPU_RETIRE_BYPASS_EN
    check_val("bypass_rs2", 64'(bus.o_rs2), 64'h55);
`else
    check_val("nobypass_rs2", 64'(bus.o_rs2), 64'(old_x9));
`endif
    retire_check();
    check_val("x9_after", 64'(bus.o_rs2), 64'h55);

    // Retired-instruction counter wrap.
    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_r;
    #1;
    check_val("pre_wrap", bus.o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    model_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_wb(8'h20, 5'd4, 32'h1234_5678, 32'h0000_0200);
    retire_check();

    // Reset while a new tag is pending commit.
    bus.i_tag = 8'h21;
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_commit");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset again mid-sweep at index 12.
    for (int i = 0; i < 11; i++) tick();
    check_val("mid_init_rdy", 64'(bus.o_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Tag 6 pending through INIT commits on the first RUN edge.
    model_cnt = 64'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    bus.i_rs1_idx = 5'd5;
    bus.i_rs2_idx = 5'd10;
    drive_wb(8'd6, 5'd10, 32'h0000_A5A5, 32'h0000_0300);
    wait_ready("reinit_len");
    check_val("exit_tag", 64'(bus.o_tag), 64'd0);
    retire_check();
    check_val("x5_cleared", 64'(bus.o_rs1), 64'd0);
    check_val("x10_val", 64'(bus.o_rs2), 64'h0000_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_retire.md
CPU_RETIRE -- requirements
Module: cpu_retire

Interface
REQ-001 SHALL have parameter TAG_W, default = width of the shared TAG_SIZE define; width of the writeback tag.
REQ-002 SHALL have parameter INIT_CYCLES, default 31; number of register-clear sweep cycles, fixed to 31 (one per x1..x31).
REQ-003 SHALL have port i_clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports i_tag in TAG_W, i_inst_rd in 5, i_rd in 32, i_pc_next in 32: writeback-stage output bundle; a new instruction is signalled by i_tag differing from the last committed tag.
REQ-006 SHALL have ports i_rs1_idx in 5, i_rs2_idx in 5: decode read indices.
REQ-007 SHALL have ports o_rs1 out 32, o_rs2 out 32: register read data.
REQ-008 SHALL have port o_tag out TAG_W: last committed tag, the acknowledge returned to the pipeline.
REQ-009 SHALL have port o_pc_next out 32: pc_next of the last committed instruction.
REQ-010 SHALL have port o_ready out 1: high in RUN state only.
REQ-011 SHALL have port o_instret out 64: retired-instruction count.

Function
REQ-012 SHALL implement a two-state FSM: INIT, RUN; reset enters INIT.
REQ-013 INIT SHALL write 0 to x1..x31 in ascending order, one per cycle, using a 5-bit sweep counter; after x31 is written, next state is RUN (31 cycles in INIT).
REQ-014 In INIT, incoming tags SHALL be ignored: no commit; o_tag, o_pc_next and o_instret SHALL hold; o_ready = 0.
REQ-015 In RUN, commit SHALL occur on any edge where i_tag != o_tag; there is no other handshake signal.
REQ-016 On commit: regs[i_inst_rd] <= i_rd when i_inst_rd != 0; o_tag <= i_tag; o_pc_next <= i_pc_next; o_instret <= o_instret + 1.
REQ-017 Commit latency SHALL be one edge; back-to-back distinct tags on consecutive cycles SHALL each commit.
REQ-018 A tag that is stable and equal to o_tag SHALL cause no write and no count, however long it is held.
REQ-019 A nonzero tag pending when INIT exits SHALL commit on the first RUN edge.
REQ-020 i_inst_rd = 0 SHALL still commit (tag, pc, count) but SHALL NOT write x0.
REQ-021 Reads SHALL be combinational: index 0 returns 0; in INIT both reads return 0.
REQ-022 o_instret SHALL wrap from 2^64-1 to 0 without any flag.

Reset
REQ-023 Asserting i_reset_n low at any time, including mid-INIT or mid-commit, SHALL immediately set o_tag = 0, o_pc_next = 0, o_instret = 0, o_ready = 0, sweep counter = 1, and state = INIT.
REQ-024 Register array contents SHALL NOT be reset asynchronously; they are cleared only by the INIT sweep.

Configuration
REQ-025 With CPU_RETIRE_BYPASS_EN defined: a read of index N (N != 0) in a cycle with a RUN-state commit to rd = N SHALL return i_rd.
REQ-026 Without CPU_RETIRE_BYPASS_EN: reads SHALL return stored array contents only, so a commit becomes visible on the cycle after the commit edge.

Structure
REQ-027 FSM state encodings and the TAG_SIZE-derived width SHALL live in the shared CPU defines file; no local magic numbers.
REQ-028 The 31x32 array with its two read ports and one write port SHALL be a sub-module, cpu_retire_regs; bypass, FSM and counters stay in cpu_retire.

Verification
REQ-029 Release reset, hold i_tag = 0 -> o_ready rises after exactly 31 cycles; o_tag = 0; o_instret = 0; reads of x1..x31 = 0.
REQ-030 In RUN, drive tag 1, rd = 5, data 0xDEADBEEF, pc_next 0x104 -> after one edge o_tag = 1, o_pc_next = 0x104, o_instret = 1, and rs1 = 5 reads 0xDEADBEEF; hold tag 1 for 10 cycles -> o_instret stays 1.
REQ-031 Drive tags 2, 3, 4 on consecutive cycles with rd = 0, 7, 7 and data 1, 2, 3 -> o_instret = 4, x0 reads 0, x7 reads 3.
REQ-032 Bypass: in the commit cycle of tag 5 with rd = 9 and data 0x55, read rs2 = 9 -> 0x55 with CPU_RETIRE_BYPASS_EN defined; old x9 value without it.
REQ-033 Assert i_reset_n mid-INIT at sweep index 12, and separately during a commit -> outputs zero immediately; a full 31-cycle sweep follows; tag 6 presented during INIT commits on the first RUN edge.
REQ-034 Force o_instret to 0xFFFF_FFFF_FFFF_FFFF, then commit one tag -> o_instret = 0.
